// File: rtl/data_cache_pkg.sv
// Shared types and width helpers for the direct-mapped write-through data cache.
package data_cache_pkg;

  localparam logic [1:0] MT_BYTE = 2'b00;
  localparam logic [1:0] MT_HALF = 2'b01;
  localparam logic [1:0] MT_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  function automatic int idxBits(input int n);
    return $clog2(n);
  endfunction

  // Tag is whatever remains above byte offset, word index and set index.
  function automatic int tagBits(input int aw, input int sets, input int lineWords);
    return aw - 2 - idxBits(sets) - idxBits(lineWords);
  endfunction

endpackage

// File: rtl/data_cache_lsu_align.sv
// Byte-lane steering for loads/stores: load extract + extend, store replicate + strobes, misalign detect.
module lsu_align
  import data_cache_pkg::*;
#(
  parameter  int DW        = 32,
  localparam int NUM_LANES = DW / 8
) (
  input  logic [1:0]                 off,
  input  logic [1:0]                 memtype,
  input  logic                       memsign,
  input  logic [DW-1:0]              wd,
  input  logic [DW-1:0]              rword,
  output logic [DW-1:0]              rdExt,
  output logic [DW-1:0]              wdLane,
  output logic [NUM_LANES-1:0]       wstrb,
  output logic                       misalign
);

  logic [1:0]                  alignOff;
  logic [15:0]                 lowHalf;
  logic [NUM_LANES-1:0][7:0]   wdBytes;

  // Misaligned accesses fall back to the naturally aligned lane.
  always_comb begin
    case (memtype)
      MT_BYTE: alignOff = off;
      MT_HALF: alignOff = {off[1], 1'b0};
      default: alignOff = 2'b00;
    endcase
  end

  assign misalign = (memtype == MT_BYTE) ? 1'b0 :
                    (memtype == MT_HALF) ? off[0] : |off;

  assign lowHalf = 16'(rword >> {alignOff, 3'b000});

  always_comb begin
    case (memtype)
      MT_BYTE: rdExt = {{(DW-8){memsign & lowHalf[7]}}, lowHalf[7:0]};
      MT_HALF: rdExt = {{(DW-16){memsign & lowHalf[15]}}, lowHalf};
      default: rdExt = rword;
    endcase
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : gLane
    localparam logic [1:0] LANE = 2'(l);
    assign wdBytes[l] = (memtype == MT_BYTE) ? wd[7:0] :
                        (memtype == MT_HALF) ? wd[8*(l%2) +: 8] : wd[8*l +: 8];
    assign wstrb[l]   = (memtype == MT_BYTE) ? (alignOff == LANE) :
                        (memtype == MT_HALF) ? (alignOff[1] == LANE[1]) : 1'b1;
  end

  assign wdLane = wdBytes;

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache fronting a word-wide req/ack bus.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   wd_i,
  input  logic [1:0]      memtype_i,
  input  logic            memsign_i,
  output logic [DW-1:0]   rd_o,
  output logic            stall_o,
  output logic            misalign_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wd_o,
  output logic [3:0]      mem_wstrb_o,
  input  logic            mem_ack_i,
  input  logic [DW-1:0]   mem_rd_i
);

  localparam int WB        = idxBits(LINE_WORDS);
  localparam int SB        = idxBits(SETS);
  localparam int TB        = tagBits(AW, SETS, LINE_WORDS);
  localparam int NUM_LANES = DW / 8;

  state_t                          state;
  logic [WB-1:0]                   cnt;
  logic [SETS-1:0]                 valid;
  logic [TB-1:0]                   tagArr  [SETS];
  logic [LINE_WORDS-1:0][DW-1:0]   dataArr [SETS];

  logic                  memReqQ, memWeQ;
  logic [AW-1:0]         memAddrQ;
  logic [DW-1:0]         memWdQ;
  logic [NUM_LANES-1:0]  memWstrbQ;

  logic [SB-1:0] reqSet, busSet;
  logic [WB-1:0] reqWord, busWord;
  logic [TB-1:0] reqTag, busTag;
  logic          hit, busHit, misal;
  logic [DW-1:0] rdExt, wdLane;
  logic [NUM_LANES-1:0] wstrbLane;

  assign reqWord = addr_i[2 +: WB];
  assign reqSet  = addr_i[2+WB +: SB];
  assign reqTag  = addr_i[AW-1 -: TB];
  assign hit     = valid[reqSet] && (tagArr[reqSet] == reqTag);

  // The latched bus address outlives req_i, so completion keys off it.
  assign busWord = memAddrQ[2 +: WB];
  assign busSet  = memAddrQ[2+WB +: SB];
  assign busTag  = memAddrQ[AW-1 -: TB];
  assign busHit  = valid[busSet] && (tagArr[busSet] == busTag);

  lsu_align #(.DW(DW)) uAlign (
    .off      (addr_i[1:0]),
    .memtype  (memtype_i),
    .memsign  (memsign_i),
    .wd       (wd_i),
    .rword    (dataArr[reqSet][reqWord]),
    .rdExt    (rdExt),
    .wdLane   (wdLane),
    .wstrb    (wstrbLane),
    .misalign (misal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      valid     <= '0;
      memReqQ   <= 1'b0;
      memWeQ    <= 1'b0;
      memAddrQ  <= '0;
      memWdQ    <= '0;
      memWstrbQ <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i && we_i) begin
            state     <= WRITE;
            memReqQ   <= 1'b1;
            memWeQ    <= 1'b1;
            memAddrQ  <= {addr_i[AW-1:2], 2'b00};
            memWdQ    <= wdLane;
            memWstrbQ <= wstrbLane;
          end else if (req_i && !hit) begin
            state    <= REFILL;
            cnt      <= '0;
            memReqQ  <= 1'b1;
            memWeQ   <= 1'b0;
            memAddrQ <= {addr_i[AW-1:2+WB], {WB{1'b0}}, 2'b00};
          end
        end
        REFILL: begin
          if (mem_ack_i) begin
            cnt      <= cnt + 1'b1;
            memAddrQ <= memAddrQ + AW'(4);
            if (cnt == WB'(LINE_WORDS-1)) begin
              valid[busSet]  <= 1'b1;
              tagArr[busSet] <= busTag;
              memReqQ        <= 1'b0;
              state          <= IDLE;
            end
          end
        end
        default: begin
          if (mem_ack_i) begin
            memReqQ   <= 1'b0;
            memWeQ    <= 1'b0;
            memWstrbQ <= '0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

  // Line storage has no reset; validity alone decides whether it is trusted.
  always_ff @(posedge clk) begin
    if (!rst && mem_ack_i) begin
      if (state == REFILL) begin
        dataArr[busSet][cnt] <= mem_rd_i;
      end else if (state == WRITE && busHit) begin
        for (int b = 0; b < NUM_LANES; b++)
          if (memWstrbQ[b]) dataArr[busSet][busWord][8*b +: 8] <= memWdQ[8*b +: 8];
      end
    end
  end

  always_comb begin
    stall_o = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    stall_o = req_i && (we_i || !hit);
        REFILL:  stall_o = 1'b1;
        default: stall_o = !mem_ack_i;
      endcase
    end
  end

  assign rd_o        = (!rst && state == IDLE && req_i && !we_i && hit) ? rdExt : '0;
  assign misalign_o  = !rst && req_i && misal;
  assign mem_req_o   = memReqQ && !rst;
  assign mem_we_o    = memWeQ && !rst;
  assign mem_addr_o  = memAddrQ;
  assign mem_wd_o    = memWdQ;
  assign mem_wstrb_o = rst ? 4'b0000 : memWstrbQ;

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus randomized traffic against a memory-level model.
module tb_data_cache;
  import data_cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0, we_i = 1'b0, memsign_i = 1'b0;
  logic [31:0] addr_i = '0, wd_i = '0;
  logic [1:0]  memtype_i = 2'b00;
  logic [31:0] rd_o, mem_addr_o, mem_wd_o;
  logic        stall_o, misalign_o, mem_req_o, mem_we_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rd_i = '0;

  int checks = 0, failures = 0;
  int ackGap = 2, lat = 0, rdCount = 0, wrCount = 0;
  logic [31:0] rdAddrQ [$];
  logic [31:0] lastWrAddr, lastWrData, wtmp;
  logic [3:0]  lastWrStrb;

  bit [31:0] bmem [bit [31:0]];
  bit [31:0] gold [bit [31:0]];
  bit        mValid [16];
  bit [23:0] mTag   [16];

  data_cache dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wd_i(wd_i),
    .memtype_i(memtype_i), .memsign_i(memsign_i), .rd_o(rd_o), .stall_o(stall_o),
    .misalign_o(misalign_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_ack_i(mem_ack_i), .mem_rd_i(mem_rd_i)
  );

  always #5 clk = ~clk;

  function automatic bit [31:0] initWord(input bit [31:0] a);
    return a * 32'h9E3779B1 + 32'h01234567;
  endfunction

  function automatic bit [31:0] bmemRd(input bit [31:0] a);
    return bmem.exists(a) ? bmem[a] : initWord(a);
  endfunction

  function automatic bit [31:0] goldRd(input bit [31:0] a);
    return gold.exists(a) ? gold[a] : initWord(a);
  endfunction

  // Backing memory: acks every ackGap-th cycle of an outstanding request.
  always @(negedge clk) begin
    mem_ack_i = 1'b0;
    if (mem_req_o === 1'b1) begin
      if (lat >= ackGap - 1) begin
        lat = 0;
        mem_ack_i = 1'b1;
        if (mem_we_o) begin
          wtmp = bmemRd(mem_addr_o);
          for (int b = 0; b < 4; b++) if (mem_wstrb_o[b]) wtmp[8*b +: 8] = mem_wd_o[8*b +: 8];
          bmem[mem_addr_o] = wtmp;
          lastWrAddr = mem_addr_o; lastWrData = mem_wd_o; lastWrStrb = mem_wstrb_o;
          wrCount++;
        end else begin
          mem_rd_i = bmemRd(mem_addr_o);
          rdAddrQ.push_back(mem_addr_o);
          rdCount++;
        end
      end else lat++;
    end else lat = 0;
  end

  function automatic bit [31:0] expLoad(input bit [31:0] a, input bit [1:0] mt, input bit sg);
    bit [31:0] w, v;
    int sh;
    w = goldRd({a[31:2], 2'b00});
    if (mt == 2'd0) begin
      sh = 8 * a[1:0];
      v = (w >> sh) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else if (mt == 2'd1) begin
      sh = 16 * a[1];
      v = (w >> sh) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end else v = w;
    return v;
  endfunction

  function automatic void goldStore(input bit [31:0] a, input bit [1:0] mt, input bit [31:0] wd);
    bit [31:0] w;
    w = goldRd({a[31:2], 2'b00});
    if (mt == 2'd0)      w[8*a[1:0] +: 8]  = wd[7:0];
    else if (mt == 2'd1) w[16*a[1] +: 16]  = wd[15:0];
    else                 w = wd;
    gold[{a[31:2], 2'b00}] = w;
  endfunction

  function automatic void setWord(input bit [31:0] a, input bit [31:0] v);
    bmem[a] = v; gold[a] = v;
  endfunction

  function automatic bit modelHit(input bit [31:0] a);
    return mValid[a[7:4]] && mTag[a[7:4]] == a[31:8];
  endfunction

  function automatic void modelFill(input bit [31:0] a);
    mValid[a[7:4]] = 1'b1; mTag[a[7:4]] = a[31:8];
  endfunction

  function automatic void modelFlush();
    for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
  endfunction

  // One core access: returns load data, stall cycle count and misalign flag.
  task automatic access(input bit we, input bit [31:0] a, input bit [31:0] wd, input bit [1:0] mt,
                        input bit sg, output bit [31:0] rd, output int stalls, output bit mis);
    @(negedge clk);
    req_i = 1'b1; we_i = we; addr_i = a; wd_i = wd; memtype_i = mt; memsign_i = sg;
    #1;
    mis = misalign_o;
    stalls = 0;
    while (stall_o !== 1'b0 && stalls < 100) begin
      stalls++;
      @(negedge clk); #1;
    end
    rd = rd_o;
    req_i = 1'b0;
    if (stalls >= 100) begin
      checks++; failures++;
      $display("FAIL access_timeout addr=%h still stalled after %0d cycles", a, stalls);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = 32'h102; memtype_i = MT_WORD;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL reset_mem_req got %b want 0", mem_req_o); end
    checks++; if (mem_we_o !== 1'b0) begin failures++; $display("FAIL reset_mem_we got %b want 0", mem_we_o); end
    checks++; if (mem_wstrb_o !== 4'b0) begin failures++; $display("FAIL reset_wstrb got %b want 0000", mem_wstrb_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got %b want 0", stall_o); end
    checks++; if (rd_o !== 32'h0) begin failures++; $display("FAIL reset_rd got %h want 0", rd_o); end
    checks++; if (misalign_o !== 1'b0) begin failures++; $display("FAIL reset_misalign got %b want 0", misalign_o); end
    @(negedge clk);
    rst = 1'b0; req_i = 1'b0;
    #1;
    checks++; if (rd_o !== 32'h0 || stall_o !== 1'b0) begin
      failures++; $display("FAIL idle_noreq got rd=%h stall=%b want rd=0 stall=0", rd_o, stall_o);
    end
    modelFlush();
  endtask

  task automatic test_refill();
    bit [31:0] rd; int st; bit mis; int r0;
    setWord(32'h100, 32'h11111111); setWord(32'h104, 32'h22222222);
    setWord(32'h108, 32'h33333333); setWord(32'h10C, 32'h44444444);
    ackGap = 2; rdAddrQ.delete(); r0 = rdCount;
    access(1'b0, 32'h100, 32'h0, MT_WORD, 1'b0, rd, st, mis);
    modelFill(32'h100);
    checks++; if (st != 9) begin failures++; $display("FAIL refill_stall got %0d want 9", st); end
    checks++; if (rd !== 32'h11111111) begin failures++; $display("FAIL refill_rd got %h want 11111111", rd); end
    checks++; if (rdCount - r0 != 4) begin failures++; $display("FAIL refill_reads got %0d want 4", rdCount - r0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdAddrQ.size() <= i || rdAddrQ[i] !== 32'h100 + 32'(4*i)) begin
        failures++; $display("FAIL refill_addr%0d got %h want %h", i, (rdAddrQ.size() > i) ? rdAddrQ[i] : 32'hx, 32'h100 + 32'(4*i));
      end
    end
  endtask

  task automatic test_load_ext();
    bit [31:0] rd; int st; bit mis;
    setWord(32'h140, 32'h80FF7F01);
    access(1'b0, 32'h140, 32'h0, MT_WORD, 1'b0, rd, st, mis);
    modelFill(32'h140);
    checks++; if (st != 9) begin failures++; $display("FAIL ext_fill_stall got %0d want 9", st); end
    access(1'b0, 32'h143, 32'h0, MT_BYTE, 1'b1, rd, st, mis);
    checks++; if (rd !== 32'hFFFFFF80 || st != 0) begin failures++; $display("FAIL lb_signed got %h/%0d want ffffff80/0", rd, st); end
    access(1'b0, 32'h143, 32'h0, MT_BYTE, 1'b0, rd, st, mis);
    checks++; if (rd !== 32'h00000080 || st != 0) begin failures++; $display("FAIL lbu got %h/%0d want 00000080/0", rd, st); end
    access(1'b0, 32'h142, 32'h0, MT_HALF, 1'b1, rd, st, mis);
    checks++; if (rd !== 32'hFFFF80FF) begin failures++; $display("FAIL lh_signed got %h want ffff80ff", rd); end
    access(1'b0, 32'h140, 32'h0, MT_HALF, 1'b0, rd, st, mis);
    checks++; if (rd !== 32'h00007F01) begin failures++; $display("FAIL lhu got %h want 00007f01", rd); end
  endtask

  task automatic test_store_hit();
    bit [31:0] rd; int st; bit mis; int w0, r0;
    ackGap = 2; w0 = wrCount;
    access(1'b1, 32'h101, 32'h000000AB, MT_BYTE, 1'b0, rd, st, mis);
    goldStore(32'h101, MT_BYTE, 32'hAB);
    checks++; if (st != 2) begin failures++; $display("FAIL sb_stall got %0d want 2", st); end
    checks++; if (wrCount - w0 != 1) begin failures++; $display("FAIL sb_writes got %0d want 1", wrCount - w0); end
    checks++; if (lastWrData !== 32'hABABABAB) begin failures++; $display("FAIL sb_wd got %h want abababab", lastWrData); end
    checks++; if (lastWrStrb !== 4'b0010) begin failures++; $display("FAIL sb_wstrb got %b want 0010", lastWrStrb); end
    checks++; if (lastWrAddr !== 32'h100) begin failures++; $display("FAIL sb_addr got %h want 00000100", lastWrAddr); end
    r0 = rdCount;
    access(1'b0, 32'h100, 32'h0, MT_WORD, 1'b0, rd, st, mis);
    checks++; if (rd !== 32'h1111AB11 || st != 0 || rdCount != r0) begin
      failures++; $display("FAIL sb_merge got rd=%h stall=%0d reads=%0d want 1111ab11/0/0", rd, st, rdCount - r0);
    end
  endtask

  task automatic test_store_miss();
    bit [31:0] rd; int st; bit mis; int r0;
    ackGap = 2;
    access(1'b1, 32'h2000, 32'hCAFEF00D, MT_WORD, 1'b0, rd, st, mis);
    goldStore(32'h2000, MT_WORD, 32'hCAFEF00D);
    checks++; if (lastWrStrb !== 4'b1111 || lastWrAddr !== 32'h2000) begin
      failures++; $display("FAIL sw_miss_bus got strb=%b addr=%h want 1111/00002000", lastWrStrb, lastWrAddr);
    end
    r0 = rdCount;
    access(1'b0, 32'h2000, 32'h0, MT_WORD, 1'b0, rd, st, mis);
    modelFill(32'h2000);
    checks++; if (st != 9 || rdCount - r0 != 4) begin
      failures++; $display("FAIL no_allocate got stall=%0d reads=%0d want 9/4", st, rdCount - r0);
    end
    checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL sw_miss_rd got %h want cafef00d", rd); end
  endtask

  task automatic test_reset_refill();
    bit [31:0] rd; int st; bit mis; int r0, n;
    ackGap = 2; r0 = rdCount; n = 0;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h100; memtype_i = MT_WORD; memsign_i = 1'b0;
    #1;
    while (rdCount - r0 < 2 && n < 50) begin @(negedge clk); #1; n++; end
    checks++; if (rdCount - r0 != 2) begin failures++; $display("FAIL rst_partial_reads got %0d want 2", rdCount - r0); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL rst_abandon mem_req got %b want 0", mem_req_o); end
    req_i = 1'b0;
    modelFlush();
    r0 = rdCount;
    access(1'b0, 32'h100, 32'h0, MT_WORD, 1'b0, rd, st, mis);
    modelFill(32'h100);
    checks++; if (rdCount - r0 != 4 || st != 9) begin
      failures++; $display("FAIL rst_refill got reads=%0d stall=%0d want 4/9", rdCount - r0, st);
    end
    checks++; if (rd !== 32'h1111AB11) begin failures++; $display("FAIL rst_refill_rd got %h want 1111ab11", rd); end
  endtask

  task automatic test_misalign();
    bit [31:0] rd; int st; bit mis;
    access(1'b0, 32'h102, 32'h0, MT_WORD, 1'b0, rd, st, mis);
    checks++; if (mis !== 1'b1 || rd !== 32'h1111AB11 || st != 0) begin
      failures++; $display("FAIL lw_misalign got mis=%b rd=%h stall=%0d want 1/1111ab11/0", mis, rd, st);
    end
    access(1'b0, 32'h103, 32'h0, MT_HALF, 1'b1, rd, st, mis);
    checks++; if (mis !== 1'b1 || rd !== 32'h00001111) begin
      failures++; $display("FAIL lh_misalign got mis=%b rd=%h want 1/00001111", mis, rd);
    end
    access(1'b0, 32'h100, 32'h0, MT_WORD, 1'b0, rd, st, mis);
    checks++; if (mis !== 1'b0) begin failures++; $display("FAIL lw_aligned misalign got %b want 0", mis); end
  endtask

  task automatic test_random();
    bit [31:0] a, wd, rd, expRd; bit [1:0] mt; bit we, sg, mis, expMis, hit;
    int st, expSt, r0, w0;
    bit [3:0] expStrb;
    for (int i = 0; i < 300; i++) begin
      we = ($urandom % 3) == 0;
      a  = {22'h0, 2'($urandom % 3), 4'($urandom % 4), 2'($urandom), 2'($urandom)};
      mt = 2'($urandom); sg = 1'($urandom); wd = $urandom;
      ackGap = 1 + ($urandom % 3);
      expMis = (mt == 2'd1) ? a[0] : (mt >= 2'd2) ? (a[1:0] != 2'b00) : 1'b0;
      r0 = rdCount; w0 = wrCount;
      if (we) begin
        expStrb = (mt == 2'd0) ? (4'b0001 << a[1:0]) : (mt == 2'd1) ? (4'b0011 << (2*a[1])) : 4'b1111;
        access(1'b1, a, wd, mt, sg, rd, st, mis);
        goldStore(a, mt, wd);
        checks++; if (st != ackGap || wrCount - w0 != 1) begin
          failures++; $display("FAIL rnd%0d_store got stall=%0d writes=%0d want %0d/1", i, st, wrCount - w0, ackGap);
        end
        checks++; if (lastWrStrb !== expStrb || lastWrAddr !== {a[31:2], 2'b00}) begin
          failures++; $display("FAIL rnd%0d_store_bus got strb=%b addr=%h want %b/%h", i, lastWrStrb, lastWrAddr, expStrb, {a[31:2], 2'b00});
        end
      end else begin
        hit   = modelHit(a);
        expSt = hit ? 0 : 1 + 4 * ackGap;
        expRd = expLoad(a, mt, sg);
        access(1'b0, a, wd, mt, sg, rd, st, mis);
        if (!hit) modelFill(a);
        checks++; if (rd !== expRd) begin failures++; $display("FAIL rnd%0d_load addr=%h mt=%0d got %h want %h", i, a, mt, rd, expRd); end
        checks++; if (st != expSt || rdCount - r0 != (hit ? 0 : 4)) begin
          failures++; $display("FAIL rnd%0d_timing got stall=%0d reads=%0d want %0d/%0d", i, st, rdCount - r0, expSt, hit ? 0 : 4);
        end
      end
      checks++; if (mis !== expMis) begin failures++; $display("FAIL rnd%0d_misalign got %b want %b", i, mis, expMis); end
    end
  endtask

  initial begin
    test_reset();
    test_refill();
    test_load_ext();
    test_store_hit();
    test_store_miss();
    test_reset_refill();
    test_misalign();
    test_random();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
